// File: rtl/mem_chk_pkg.sv
// Shared types for the LC-3 memory-bus checker:
// read FSM states, error codes and the error priority encoder.
package mem_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STALL
  } rd_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DUP_WR  = 3'd1,
    ERR_RD_MIS  = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_ABORT   = 3'd4,
    ERR_WE_RE   = 3'd5
  } err_code_e;

  // ev[0]=dup_wr .. ev[4]=we_re; lowest code wins
  function automatic err_code_e first_code(input logic [4:0] ev);
    err_code_e c;
    c = ERR_NONE;
    if (ev[4]) c = ERR_WE_RE;
    if (ev[3]) c = ERR_ABORT;
    if (ev[2]) c = ERR_TIMEOUT;
    if (ev[1]) c = ERR_RD_MIS;
    if (ev[0]) c = ERR_DUP_WR;
    return c;
  endfunction

endpackage

// File: rtl/mem_chk_hist.sv
// Shallow write history: shift-in on push, duplicate-window
// compare and youngest-first address lookup (entry 0 = youngest).
module mem_chk_hist
  import mem_chk_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int HIST_DEPTH = 4,
  parameter int DUP_WINDOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              dup_hit,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } hist_entry_t;

  hist_entry_t hist [HIST_DEPTH];

  // shift register: new write enters entry 0, oldest drops out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (push) begin
      hist[0] <= '{valid: 1'b1, addr: addr, data: wdata};
      for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  // duplicate check over the youngest DUP_WINDOW entries
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DUP_WINDOW; i++) begin
      if (hist[i].valid && hist[i].addr == addr) dup_hit = 1'b1;
    end
  end

  // oldest-to-youngest scan so the youngest match overwrites
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (hist[i].valid && hist[i].addr == addr) begin
        lk_hit  = 1'b1;
        lk_data = hist[i].data;
      end
    end
  end

endmodule

// File: rtl/mem_bus_checker.sv
// Passive LC-3 memory-bus checker: counters, read FSM, sticky errors.
// Define MEM_BUS_CHECKER_LOG_EN for simulation logging of bus events.
module mem_bus_checker
  import mem_chk_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int HIST_DEPTH = 4,
  parameter int DUP_WINDOW = 1,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic              err_dup_wr,
  output logic              err_rd_mis,
  output logic              err_timeout,
  output logic              err_abort,
  output logic              err_we_re,
  output logic [2:0]        first_err_code,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [WC_W-1:0] WC_TO  = WC_W'(TIMEOUT);

  rd_state_e         state, state_nx;
  logic [WC_W-1:0]   wcnt, wcnt_nx;
  logic              ev_to, ev_ab;
  logic              dup_hit, lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic              rd_done;
  logic [4:0]        ev;

  mem_chk_hist #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .HIST_DEPTH (HIST_DEPTH),
    .DUP_WINDOW (DUP_WINDOW)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (mem_we),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .dup_hit (dup_hit),
    .lk_hit  (lk_hit),
    .lk_data (lk_data)
  );

  assign rd_done = mem_re && mem_ready;

  // this cycle's error events, bit i = code i+1
  assign ev = {
    mem_we && mem_re,
    ev_ab,
    ev_to,
    rd_done && lk_hit && (lk_data != mem_rdata),
    mem_we && dup_hit
  };

  // read FSM state and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else if (clr) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // read FSM next state, timeout and abort detection
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    ev_to    = 1'b0;
    ev_ab    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_re && !mem_ready) begin
          wcnt_nx = WC_ONE;
          if (WC_ONE == WC_TO) begin
            ev_to    = 1'b1;
            state_nx = STALL;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nx = IDLE;
        end else if (!mem_re) begin
          state_nx = IDLE;
          ev_ab    = 1'b1;
        end else begin
          wcnt_nx = wcnt + WC_ONE;
          if (wcnt_nx == WC_TO) begin
            ev_to    = 1'b1;
            state_nx = STALL;
          end
        end
      end
      STALL: begin
        if (mem_ready || !mem_re) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // saturating counters, sticky flags and first-error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count       <= '0;
      rd_count       <= '0;
      err_dup_wr     <= 1'b0;
      err_rd_mis     <= 1'b0;
      err_timeout    <= 1'b0;
      err_abort      <= 1'b0;
      err_we_re      <= 1'b0;
      first_err_code <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      wr_count       <= '0;
      rd_count       <= '0;
      err_dup_wr     <= 1'b0;
      err_rd_mis     <= 1'b0;
      err_timeout    <= 1'b0;
      err_abort      <= 1'b0;
      err_we_re      <= 1'b0;
      first_err_code <= '0;
      first_err_addr <= '0;
    end else begin
      if (mem_we && wr_count != '1) wr_count <= wr_count + 1'b1;
      if (rd_done && rd_count != '1) rd_count <= rd_count + 1'b1;
      err_dup_wr  <= err_dup_wr  | ev[0];
      err_rd_mis  <= err_rd_mis  | ev[1];
      err_timeout <= err_timeout | ev[2];
      err_abort   <= err_abort   | ev[3];
      err_we_re   <= err_we_re   | ev[4];
      if (first_err_code == 3'd0 && |ev) begin
        first_err_code <= first_code(ev);
        first_err_addr <= mem_addr;
      end
    end
  end

`ifdef MEM_BUS_CHECKER_LOG_EN
  // simulation trace of bus events and error occurrences
  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      if (mem_we)
        $display("[MEM-WR] t=%0t addr=%h data=%h",
                 $time, mem_addr, mem_wdata);
      if (rd_done)
        $display("[MEM-RD] t=%0t addr=%h data=%h",
                 $time, mem_addr, mem_rdata);
      if (|ev) begin
        $display("[CHK-ERR] code=%0d addr=%h",
                 first_code(ev), mem_addr);
        $error("mem_bus_checker error code %0d", first_code(ev));
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_checker.sv
// Scoreboard bench for mem_bus_checker (TIMEOUT=4):
// expected outputs queued per driven cycle, popped after the edge.
module tb_mem_bus_checker;

  localparam logic [4:0] F_DUP = 5'b00001;
  localparam logic [4:0] F_MIS = 5'b00010;
  localparam logic [4:0] F_TO  = 5'b00100;
  localparam logic [4:0] F_AB  = 5'b01000;
  localparam logic [4:0] F_WR  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] wr_count, rd_count;
  logic        err_dup_wr, err_rd_mis, err_timeout;
  logic        err_abort, err_we_re;
  logic [2:0]  first_err_code;
  logic [15:0] first_err_addr;

  typedef struct {
    logic [15:0] wr;
    logic [15:0] rd;
    logic [4:0]  fl;
    logic [2:0]  code;
    logic [15:0] addr;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_checker #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .HIST_DEPTH (4),
    .DUP_WINDOW (1),
    .TIMEOUT    (4),
    .CNT_W      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .wr_count       (wr_count),
    .rd_count       (rd_count),
    .err_dup_wr     (err_dup_wr),
    .err_rd_mis     (err_rd_mis),
    .err_timeout    (err_timeout),
    .err_abort      (err_abort),
    .err_we_re      (err_we_re),
    .first_err_code (first_err_code),
    .first_err_addr (first_err_addr)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // drive one cycle, queue its expectation, then compare after the edge
  task automatic step(input string tag,
                      input logic c, we, re, rdy,
                      input logic [15:0] a, wd, rdd,
                      input int ewr, erd,
                      input logic [4:0] efl,
                      input int ecode,
                      input logic [15:0] eaddr);
    exp_t e, o;
    string t;
    clr = c; mem_we = we; mem_re = re; mem_ready = rdy;
    mem_addr = a; mem_wdata = wd; mem_rdata = rdd;
    e.wr = 16'(ewr); e.rd = 16'(erd); e.fl = efl;
    e.code = 3'(ecode); e.addr = eaddr;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    o = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".wr"}, 32'(wr_count), 32'(o.wr));
    check({t, ".rd"}, 32'(rd_count), 32'(o.rd));
    check({t, ".flags"},
          32'({err_we_re, err_abort, err_timeout,
               err_rd_mis, err_dup_wr}), 32'(o.fl));
    check({t, ".code"}, 32'(first_err_code), 32'(o.code));
    check({t, ".addr"}, 32'(first_err_addr), 32'(o.addr));
  endtask

  task automatic do_clr(input string tag);
    step(tag, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 5'b0, 0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    step("reset", 0, 1, 1, 1, 16'h1234, 16'h1, 16'h2,
         0, 0, 5'b0, 0, 16'h0);
    rst = 1'b0;
    step("idle", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0,
         0, 0, 5'b0, 0, 16'h0);

    // clean writes then matching read
    step("w3000", 0, 1, 0, 0, 16'h3000, 16'h1111, 16'h0,
         1, 0, 5'b0, 0, 16'h0);
    step("w3001", 0, 1, 0, 0, 16'h3001, 16'h2222, 16'h0,
         2, 0, 5'b0, 0, 16'h0);
    step("r3001", 0, 0, 1, 1, 16'h3001, 16'h0, 16'h2222,
         2, 1, 5'b0, 0, 16'h0);

    // back-to-back duplicate write
    do_clr("clr1");
    step("dup_a", 0, 1, 0, 0, 16'h3000, 16'h5, 16'h0,
         1, 0, 5'b0, 0, 16'h0);
    step("dup_b", 0, 1, 0, 0, 16'h3000, 16'h6, 16'h0,
         2, 0, F_DUP, 1, 16'h3000);

    // read data mismatch
    do_clr("clr2");
    step("w4000", 0, 1, 0, 0, 16'h4000, 16'hAAAA, 16'h0,
         1, 0, 5'b0, 0, 16'h0);
    step("rmis", 0, 0, 1, 1, 16'h4000, 16'h0, 16'hAAAB,
         1, 1, F_MIS, 2, 16'h4000);

    // timeout after the 4th wait cycle, then late ready
    do_clr("clr3");
    for (int i = 1; i <= 6; i++) begin
      if (i < 4)
        step("wait", 0, 0, 1, 0, 16'h5000, 16'h0, 16'h0,
             0, 0, 5'b0, 0, 16'h0);
      else
        step("tmo", 0, 0, 1, 0, 16'h5000, 16'h0, 16'h0,
             0, 0, F_TO, 3, 16'h5000);
    end
    step("tmo_rdy", 0, 0, 1, 1, 16'h5000, 16'h0, 16'h0,
         0, 1, F_TO, 3, 16'h5000);
    step("tmo_idle", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0,
         0, 1, F_TO, 3, 16'h5000);

    // abort, then we+re keeps first code
    do_clr("clr4");
    step("ab_w1", 0, 0, 1, 0, 16'h6000, 16'h0, 16'h0,
         0, 0, 5'b0, 0, 16'h0);
    step("ab_w2", 0, 0, 1, 0, 16'h6000, 16'h0, 16'h0,
         0, 0, 5'b0, 0, 16'h0);
    step("abort", 0, 0, 0, 0, 16'h6000, 16'h0, 16'h0,
         0, 0, F_AB, 4, 16'h6000);
    step("we_re", 0, 1, 1, 0, 16'h6100, 16'h1, 16'h0,
         1, 0, F_AB | F_WR, 4, 16'h6000);
    step("we_re2", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0,
         1, 0, F_AB | F_WR, 4, 16'h6000);

    // clr wins over a same-cycle write; history emptied
    step("clr5", 1, 1, 0, 0, 16'h6100, 16'h9, 16'h0,
         0, 0, 5'b0, 0, 16'h0);
    step("rewr", 0, 1, 0, 0, 16'h6100, 16'h1, 16'h0,
         1, 0, 5'b0, 0, 16'h0);

    // window of 1: older duplicate not flagged; youngest lookup
    step("h7000a", 0, 1, 0, 0, 16'h7000, 16'h0001, 16'h0,
         2, 0, 5'b0, 0, 16'h0);
    step("h7001", 0, 1, 0, 0, 16'h7001, 16'h0002, 16'h0,
         3, 0, 5'b0, 0, 16'h0);
    step("h7000b", 0, 1, 0, 0, 16'h7000, 16'h0003, 16'h0,
         4, 0, 5'b0, 0, 16'h0);
    step("r_young", 0, 0, 1, 1, 16'h7000, 16'h0, 16'h0003,
         4, 1, 5'b0, 0, 16'h0);
    step("r_old", 0, 0, 1, 1, 16'h7000, 16'h0, 16'h0001,
         4, 2, F_MIS, 2, 16'h7000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
